// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage pipeline: opcodes, ALU operation
// encodings and the packed control bundle carried from ID into EX.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational main-control decoder: instruction opcode to control bundle.
// Unrecognised opcodes decode to an all-zero bundle so they flow as no-ops.
module control_decoder
  import pipeline_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      default: ctrl_o = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register: register-file addressing,
// write-back bypass, load-use hazard detection and bubble insertion.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic              id_valid,
  output logic [REG_AW-1:0] read_addr_a,
  output logic [REG_AW-1:0] read_addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_data_a,
  output logic [DATA_W-1:0] ex_data_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd
);

  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] opnd_a, opnd_b, imm_ext;
  ctrl_t             dec_ctrl;

  logic              ex_valid_q, ex_valid_d;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_data_a_q, ex_data_a_d;
  logic [DATA_W-1:0] ex_data_b_q, ex_data_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [DATA_W-1:0] ex_pc_plus4_q, ex_pc_plus4_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

  assign rs = id_instr[21 +: REG_AW];
  assign rt = id_instr[16 +: REG_AW];
  assign rd = id_instr[11 +: REG_AW];

  assign read_addr_a = rs;
  assign read_addr_b = rt;

  assign imm_ext = {{(DATA_W - 16){id_instr[15]}}, id_instr[15:0]};

  control_decoder u_control_decoder (
    .opcode_i (id_instr[31:26]),
    .ctrl_o   (dec_ctrl)
  );

  // Register 0 is hard-wired zero; otherwise a concurrent write-back wins over
  // the register file, which only commits that value at the end of this cycle.
  always_comb begin
    opnd_a = data_a;
    if (rs == '0) begin
      opnd_a = '0;
    end else if (wb_reg_write && (wb_write_address == rs)) begin
      opnd_a = wb_write_data;
    end
  end

  always_comb begin
    opnd_b = data_b;
    if (rt == '0) begin
      opnd_b = '0;
    end else if (wb_reg_write && (wb_write_address == rt)) begin
      opnd_b = wb_write_data;
    end
  end

  // A load in EX whose target is read by ID cannot be forwarded in time.
  assign stall = id_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rt_q != '0) &&
                 ((ex_rt_q == rs) || (ex_rt_q == rt)) && !flush;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = CTRL_BUBBLE;
    ex_data_a_d   = '0;
    ex_data_b_d   = '0;
    ex_imm_d      = '0;
    ex_pc_plus4_d = '0;
    ex_rs_d       = '0;
    ex_rt_d       = '0;
    ex_rd_d       = '0;
    if (!flush && !stall) begin
      ex_valid_d    = id_valid;
      ex_ctrl_d     = id_valid ? dec_ctrl : CTRL_BUBBLE;
      ex_data_a_d   = opnd_a;
      ex_data_b_d   = opnd_b;
      ex_imm_d      = imm_ext;
      ex_pc_plus4_d = id_pc_plus4;
      ex_rs_d       = rs;
      ex_rt_d       = rt;
      ex_rd_d       = rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= CTRL_BUBBLE;
      ex_data_a_q   <= '0;
      ex_data_b_q   <= '0;
      ex_imm_q      <= '0;
      ex_pc_plus4_q <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_rd_q       <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_data_a_q   <= ex_data_a_d;
      ex_data_b_q   <= ex_data_b_d;
      ex_imm_q      <= ex_imm_d;
      ex_pc_plus4_q <= ex_pc_plus4_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_rd_q       <= ex_rd_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_dst    = ex_ctrl_q.reg_dst;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_data_a     = ex_data_a_q;
  assign ex_data_b     = ex_data_b_q;
  assign ex_imm        = ex_imm_q;
  assign ex_pc_plus4   = ex_pc_plus4_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign ex_rd         = ex_rd_q;

endmodule
